vp_controller: RTL and testbench
================================

# vp_controller

Sequencing controller for load value prediction in the MEM stage. Decides per load whether to speculate, using a PC-indexed confidence table, and tracks the single outstanding prediction. When the d-cache response arrives it checks the prediction and issues a one-cycle commit or recover pulse. It holds the speculation lock until the pipeline reports recovery complete, so the predictor datapath is never shared by two in-flight loads.

## Interface
- INDEX_WIDTH, 6, confidence-table index bits (2^INDEX_WIDTH entries)
- CONF_WIDTH, 2, saturating confidence counter width
- CONF_THRESH, 2, minimum confidence required to speculate
- TIMEOUT, 64, max cycles in SPEC without a d-cache response
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- ld_valid  in  1  load issuing to d-cache this cycle
- ld_pc  in  `ADDR_WIDTH  PC of issuing load
- pred_value  in  `DATA_WIDTH  predictor's value for ld_pc (valid with ld_valid)
- dc_valid  in  1  d-cache read response valid
- dc_data  in  `DATA_WIDTH  d-cache read data
- recovery_done  in  1  pipeline finished squash/replay
- spec_en  out  1  one-cycle pulse: forward spec_value as load result
- spec_value  out  `DATA_WIDTH  captured predicted value
- spec_pc  out  `ADDR_WIDTH  PC of tracked load
- vp_lock  out  1  speculation outstanding (SPEC or RECOVER)
- commit  out  1  one-cycle pulse: prediction verified correct
- recover  out  1  one-cycle pulse: misprediction, start recovery
- fix_value  out  `DATA_WIDTH  correct value for replay (captured dc_data)
- n_pred, n_mispred  out  32  statistics counters, wrap at 2^32

## Operation
- States: IDLE, TRAIN, SPEC, RECOVER. Reset: IDLE; all outputs 0; all table entries 0.
- Table index = ld_pc[INDEX_WIDTH+1:2].
- IDLE, ld_valid, conf >= CONF_THRESH: go to SPEC. Capture ld_pc→spec_pc, pred_value→spec_value. Assert spec_en next cycle. n_pred++.
- IDLE, ld_valid, conf < CONF_THRESH: go to TRAIN. Capture pc/value. No spec_en.
- TRAIN, dc_valid: on match (dc_data == captured value) conf saturating-increments; on mismatch conf clears to 0. Go to IDLE. No commit/recover.
- SPEC, dc_valid and match: conf++ (saturating), commit pulse, go to IDLE.
- SPEC, dc_valid and mismatch: conf = 0, fix_value = dc_data, recover pulse, n_mispred++, go to RECOVER.
- SPEC timeout (timer reaches TIMEOUT-1 with no dc_valid): recover pulse, fix_value unchanged, n_mispred++, conf unchanged, go to RECOVER.
- RECOVER: hold until recovery_done, then go to IDLE.
- ld_valid outside IDLE is ignored; upstream keeps one load outstanding.
- dc_valid in IDLE or RECOVER is ignored.
- recovery_done outside RECOVER is ignored.

## Timing
- All outputs are registered.
- spec_en is high exactly the cycle after ld_valid is sampled in IDLE.
- dc_valid is sampled from the first cycle in TRAIN/SPEC. A response in the issue cycle is not accepted.
- commit/recover are high exactly the cycle after the deciding dc_valid (or timeout).
- vp_lock is high from the cycle after SPEC entry through the last RECOVER cycle.
- vp_lock drops the cycle after recovery_done or commit.
- Back-to-back: a load may be accepted the first cycle vp_lock is low.
- Table write (TRAIN/SPEC exit) and table read (IDLE issue) never coincide in the same cycle, because states are exclusive.
- Timer clears on SPEC entry.
- Reset mid-operation returns to IDLE immediately (async) and drops all pulses, lock and table contents.

## Structure
- Package vp_ctrl_pkg: state enum vp_state_t, conf_t (logic [CONF_WIDTH-1:0]), SATURATE helper constant.
- Sub-module vp_conf_table: 2^INDEX_WIDTH × CONF_WIDTH flop array with one read port, one write port, async reset to 0. Holds the saturating-increment/clear update logic.
- FSM, capture registers, timer and counters live in vp_controller.

## Test plan
- Cold start, ld_pc=0x40, pred_value=0: TRAIN. With dc_data=0, entry 0x10 goes to 1. Second identical load: entry=2. Third load: spec_en pulse, n_pred=1.
- Entry at 2, pred_value=0x5, dc_data=0x5 after 3 cycles: commit pulse, entry=3, vp_lock low next cycle, no recover.
- Entry at 3, pred 0x5, dc_data=0x7: recover pulse, fix_value=0x7, entry=0, n_mispred=1. vp_lock stays high until recovery_done, then clears next cycle.
- SPEC with no dc_valid for 64 cycles: recover on cycle 64, n_mispred increments, entry unchanged. A dc_valid arriving later in RECOVER is ignored.
- ld_valid pulses while in SPEC/RECOVER, and spurious recovery_done in IDLE: no state change, no counter change.
- Assert rst_n low while in RECOVER: outputs 0, state IDLE, table cleared. The next load goes to TRAIN, not SPEC.

Source files
------------

// File: rtl/vp_controller_pkg.sv
// Shared types and constants for the load value prediction controller.
//   vp_state_t : controller FSM state
//   conf_t     : confidence counter at the default width
//   SATURATE   : saturated value of a default-width confidence counter
package vp_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned CONF_WIDTH_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRAIN   = 2'd1,
    ST_SPEC    = 2'd2,
    ST_RECOVER = 2'd3
  } vp_state_t;

  typedef logic [CONF_WIDTH_DEF-1:0] conf_t;

  localparam conf_t SATURATE = '1;

endpackage

// File: rtl/vp_controller_if.sv
// Bus bundle between the MEM stage and the value prediction controller.
//   load issue   : ld_valid, ld_pc, pred_value
//   d-cache resp : dc_valid, dc_data
//   pipeline     : recovery_done
//   results      : spec_en, spec_value, spec_pc, vp_lock, commit, recover,
//                  fix_value, n_pred, n_mispred
// master = pipeline side, slave = controller side.
interface vp_controller_if;
  import vp_ctrl_pkg::*;

  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_pc;
  logic [DATA_WIDTH-1:0] pred_value;
  logic                  dc_valid;
  logic [DATA_WIDTH-1:0] dc_data;
  logic                  recovery_done;

  logic                  spec_en;
  logic [DATA_WIDTH-1:0] spec_value;
  logic [ADDR_WIDTH-1:0] spec_pc;
  logic                  vp_lock;
  logic                  commit;
  logic                  recover;
  logic [DATA_WIDTH-1:0] fix_value;
  logic [31:0]           n_pred;
  logic [31:0]           n_mispred;

  modport master (
    output ld_valid, ld_pc, pred_value, dc_valid, dc_data, recovery_done,
    input  spec_en, spec_value, spec_pc, vp_lock, commit, recover,
           fix_value, n_pred, n_mispred
  );

  modport slave (
    input  ld_valid, ld_pc, pred_value, dc_valid, dc_data, recovery_done,
    output spec_en, spec_value, spec_pc, vp_lock, commit, recover,
           fix_value, n_pred, n_mispred
  );

endinterface

// File: rtl/vp_conf_table.sv
// PC-indexed table of saturating confidence counters.
//   clk, rst_n : clock, async active-low reset (clears every entry)
//   rd_idx     : read index; rd_conf_c is the combinational entry value
//   wr_en      : update entry wr_idx this cycle
//   wr_inc     : 1 = saturating increment, 0 = clear to zero
module vp_conf_table #(
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned CONF_WIDTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  output logic [CONF_WIDTH-1:0]  rd_conf_c,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  logic                   wr_inc
);

  localparam int unsigned            ENTRIES  = 1 << INDEX_WIDTH;
  localparam logic [CONF_WIDTH-1:0]  CONF_MAX = {CONF_WIDTH{1'b1}};

  logic [CONF_WIDTH-1:0] conf_q [ENTRIES];
  logic [CONF_WIDTH-1:0] conf_d [ENTRIES];

  assign rd_conf_c = conf_q[rd_idx];

  // Single-entry update: saturating increment on a correct value, clear otherwise.
  always_comb begin
    conf_d = conf_q;
    if (wr_en) begin
      if (!wr_inc) begin
        conf_d[wr_idx] = '0;
      end else if (conf_q[wr_idx] != CONF_MAX) begin
        conf_d[wr_idx] = conf_q[wr_idx] + CONF_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) conf_q[i] <= '0;
    end else begin
      conf_q <= conf_d;
    end
  end

endmodule

// File: rtl/vp_controller.sv
// Load value prediction sequencer: decides per load whether to speculate,
// tracks the single outstanding prediction, and verifies it against the
// d-cache response, issuing one-cycle commit/recover pulses.
//   clk, rst_n : clock, async active-low reset
//   bus        : vp_controller_if slave (load issue, d-cache response,
//                recovery handshake, speculation results and statistics)
module vp_controller
  import vp_ctrl_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned CONF_WIDTH  = CONF_WIDTH_DEF,
  parameter int unsigned CONF_THRESH = 2,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  vp_controller_if.slave  bus
);

  localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  vp_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] spec_pc_q, spec_pc_d;
  logic [DATA_WIDTH-1:0] spec_value_q, spec_value_d;
  logic [DATA_WIDTH-1:0] fix_value_q, fix_value_d;
  logic                  spec_en_q, spec_en_d;
  logic                  commit_q, commit_d;
  logic                  recover_q, recover_d;
  logic                  vp_lock_q, vp_lock_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [31:0]           n_pred_q, n_pred_d;
  logic [31:0]           n_mispred_q, n_mispred_d;

  logic [INDEX_WIDTH-1:0] rd_idx;
  logic [CONF_WIDTH-1:0]  rd_conf;
  logic                   wr_en;
  logic [INDEX_WIDTH-1:0] wr_idx;
  logic                   wr_inc;
  logic                   value_match;

  assign rd_idx      = bus.ld_pc[INDEX_WIDTH+1:2];
  assign wr_idx      = spec_pc_q[INDEX_WIDTH+1:2];
  assign value_match = (bus.dc_data == spec_value_q);

  vp_conf_table #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .CONF_WIDTH  (CONF_WIDTH)
  ) u_conf_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (rd_idx),
    .rd_conf_c (rd_conf),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_inc    (wr_inc)
  );

  // Next-state, capture, table-update and pulse generation.
  always_comb begin
    state_d      = state_q;
    spec_pc_d    = spec_pc_q;
    spec_value_d = spec_value_q;
    fix_value_d  = fix_value_q;
    spec_en_d    = 1'b0;
    commit_d     = 1'b0;
    recover_d    = 1'b0;
    timer_d      = timer_q;
    n_pred_d     = n_pred_q;
    n_mispred_d  = n_mispred_q;
    wr_en        = 1'b0;
    wr_inc       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.ld_valid) begin
          spec_pc_d    = bus.ld_pc;
          spec_value_d = bus.pred_value;
          if (rd_conf >= CONF_WIDTH'(CONF_THRESH)) begin
            state_d   = ST_SPEC;
            spec_en_d = 1'b1;
            timer_d   = '0;
            n_pred_d  = n_pred_q + 32'd1;
          end else begin
            state_d = ST_TRAIN;
          end
        end
      end

      ST_TRAIN: begin
        if (bus.dc_valid) begin
          wr_en   = 1'b1;
          wr_inc  = value_match;
          state_d = ST_IDLE;
        end
      end

      ST_SPEC: begin
        timer_d = timer_q + TIMER_W'(1);
        if (bus.dc_valid) begin
          wr_en  = 1'b1;
          wr_inc = value_match;
          if (value_match) begin
            commit_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            fix_value_d = bus.dc_data;
            recover_d   = 1'b1;
            n_mispred_d = n_mispred_q + 32'd1;
            state_d     = ST_RECOVER;
          end
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          // No response in time: recover with the old fix_value, confidence untouched.
          recover_d   = 1'b1;
          n_mispred_d = n_mispred_q + 32'd1;
          state_d     = ST_RECOVER;
        end
      end

      ST_RECOVER: begin
        if (bus.recovery_done) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    vp_lock_d = (state_d == ST_SPEC) || (state_d == ST_RECOVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      spec_pc_q    <= '0;
      spec_value_q <= '0;
      fix_value_q  <= '0;
      spec_en_q    <= 1'b0;
      commit_q     <= 1'b0;
      recover_q    <= 1'b0;
      vp_lock_q    <= 1'b0;
      timer_q      <= '0;
      n_pred_q     <= '0;
      n_mispred_q  <= '0;
    end else begin
      state_q      <= state_d;
      spec_pc_q    <= spec_pc_d;
      spec_value_q <= spec_value_d;
      fix_value_q  <= fix_value_d;
      spec_en_q    <= spec_en_d;
      commit_q     <= commit_d;
      recover_q    <= recover_d;
      vp_lock_q    <= vp_lock_d;
      timer_q      <= timer_d;
      n_pred_q     <= n_pred_d;
      n_mispred_q  <= n_mispred_d;
    end
  end

  assign bus.spec_en    = spec_en_q;
  assign bus.spec_value = spec_value_q;
  assign bus.spec_pc    = spec_pc_q;
  assign bus.vp_lock    = vp_lock_q;
  assign bus.commit     = commit_q;
  assign bus.recover    = recover_q;
  assign bus.fix_value  = fix_value_q;
  assign bus.n_pred     = n_pred_q;
  assign bus.n_mispred  = n_mispred_q;

endmodule

// File: tb/tb_vp_controller.sv
// Scoreboard bench for vp_controller: transactions push expected pulses
// (spec_en / commit / recover with cycle and payload) into a queue; a
// negedge monitor pops and compares whenever a pulse appears.
module tb_vp_controller;
  import vp_ctrl_pkg::*;

  localparam int unsigned IW = 6;
  localparam int unsigned TH = 2;
  localparam int unsigned TO = 64;

  localparam int K_SPEC    = 1;
  localparam int K_COMMIT  = 2;
  localparam int K_RECOVER = 3;

  typedef struct {
    int          kind;
    int unsigned cyc;
    logic [31:0] val;
    logic [31:0] pc;
    logic [31:0] np;
    logic [31:0] nm;
    logic        lock;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;

  vp_controller_if bus ();

  vp_controller #(
    .INDEX_WIDTH (IW),
    .CONF_WIDTH  (CONF_WIDTH_DEF),
    .CONF_THRESH (TH),
    .TIMEOUT     (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  int          conf_m [1 << IW];
  logic [31:0] np_m, nm_m, fix_m;
  ev_t         exp_q [$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (bus.spec_en || bus.commit || bus.recover)) begin
      ev_t e;
      int  k;
      k = bus.spec_en ? K_SPEC : (bus.commit ? K_COMMIT : K_RECOVER);
      chk("pulse_onehot", 32'($countones({bus.spec_en, bus.commit, bus.recover})), 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'(k), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ev_kind", 32'(k), 32'(e.kind));
        chk("ev_cycle", 32'(cyc), 32'(e.cyc));
        chk(k == K_RECOVER ? "ev_fix_value" : "ev_spec_value",
            k == K_RECOVER ? bus.fix_value : bus.spec_value, e.val);
        chk("ev_spec_pc", bus.spec_pc, e.pc);
        chk("ev_n_pred", bus.n_pred, e.np);
        chk("ev_n_mispred", bus.n_mispred, e.nm);
        chk("ev_vp_lock", 32'(bus.vp_lock), 32'(e.lock));
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < (1 << IW); i++) conf_m[i] = 0;
    np_m = '0; nm_m = '0; fix_m = '0;
    exp_q.delete();
  endtask

  task automatic conf_update(input int idx, input bit ok);
    if (!ok) conf_m[idx] = 0;
    else if (conf_m[idx] < int'(SATURATE)) conf_m[idx] = conf_m[idx] + 1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_spec_en"}, 32'(bus.spec_en), 32'd0);
    chk({tag, "_commit"}, 32'(bus.commit), 32'd0);
    chk({tag, "_recover"}, 32'(bus.recover), 32'd0);
    chk({tag, "_vp_lock"}, 32'(bus.vp_lock), 32'd0);
    chk({tag, "_n_pred"}, bus.n_pred, 32'd0);
    chk({tag, "_n_mispred"}, bus.n_mispred, 32'd0);
    chk({tag, "_spec_value"}, bus.spec_value, 32'd0);
    chk({tag, "_spec_pc"}, bus.spec_pc, 32'd0);
    chk({tag, "_fix_value"}, bus.fix_value, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_outputs_zero(tag);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_n_pred"}, bus.n_pred, np_m);
    chk({tag, "_n_mispred"}, bus.n_mispred, nm_m);
    chk({tag, "_vp_lock"}, 32'(bus.vp_lock), 32'd0);
  endtask

  // n cycles with optional ignored ld_valid / recovery_done noise.
  task automatic idle_cycles(input int unsigned n, input bit noise_ld, input bit noise_rd);
    for (int i = 0; i < int'(n); i++) begin
      if (noise_ld) begin
        bus.ld_valid   = 1'($urandom_range(0, 1));
        bus.ld_pc      = $urandom;
        bus.pred_value = $urandom;
      end
      if (noise_rd) bus.recovery_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.ld_valid      = 1'b0;
      bus.recovery_done = 1'b0;
    end
  endtask

  task automatic drive_dc(input logic [31:0] data);
    bus.dc_valid = 1'b1;
    bus.dc_data  = data;
    @(negedge clk);
    bus.dc_valid = 1'b0;
    bus.dc_data  = $urandom;
  endtask

  // One load: issue, response after `delay` idle cycles (>= TO means no
  // response before timeout), then recovery handshake if a recover occurs.
  task automatic txn(input logic [31:0] pc, input logic [31:0] pred,
                     input int unsigned delay, input logic [31:0] data,
                     input int unsigned rdelay, input bit noise, input bit rst_in_rec);
    int          idx;
    bit          spec;
    int unsigned cur;
    idx  = int'(pc[IW+1:2]);
    spec = (conf_m[idx] >= int'(TH));
    cur  = cyc;
    bus.ld_valid   = 1'b1;
    bus.ld_pc      = pc;
    bus.pred_value = pred;
    if (spec) begin
      np_m = np_m + 1;
      exp_q.push_back('{kind: K_SPEC, cyc: cur + 1, val: pred, pc: pc, np: np_m, nm: nm_m, lock: 1'b1});
    end
    @(negedge clk);
    bus.ld_valid = 1'b0;

    if (!spec) begin
      chk("train_vp_lock", 32'(bus.vp_lock), 32'd0);
      idle_cycles(delay, noise, noise);
      drive_dc(data);
      conf_update(idx, data == pred);
      return;
    end

    if (delay < TO) begin
      idle_cycles(delay, noise, noise);
      cur = cyc;
      if (data == pred) begin
        conf_update(idx, 1'b1);
        exp_q.push_back('{kind: K_COMMIT, cyc: cur + 1, val: pred, pc: pc, np: np_m, nm: nm_m, lock: 1'b0});
        drive_dc(data);
        return;
      end
      conf_update(idx, 1'b0);
      nm_m  = nm_m + 1;
      fix_m = data;
      exp_q.push_back('{kind: K_RECOVER, cyc: cur + 1, val: data, pc: pc, np: np_m, nm: nm_m, lock: 1'b1});
      drive_dc(data);
    end else begin
      cur  = cyc;
      nm_m = nm_m + 1;
      exp_q.push_back('{kind: K_RECOVER, cyc: cur + TO, val: fix_m, pc: pc, np: np_m, nm: nm_m, lock: 1'b1});
      idle_cycles(TO, noise, noise);
      idle_cycles(2, noise, 1'b0);
      drive_dc(data);  // late response lands in RECOVER and must be ignored
    end

    idle_cycles(rdelay, noise, 1'b0);
    chk("recover_vp_lock", 32'(bus.vp_lock), 32'd1);
    if (rst_in_rec) begin
      do_reset("rst_mid");
      return;
    end
    bus.recovery_done = 1'b1;
    @(negedge clk);
    bus.recovery_done = 1'b0;
    chk("after_done_vp_lock", 32'(bus.vp_lock), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc, pred, data;
    bus.ld_valid = 1'b0; bus.ld_pc = '0; bus.pred_value = '0;
    bus.dc_valid = 1'b0; bus.dc_data = '0; bus.recovery_done = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    do_reset("reset");

    // Directed: train twice, speculate/commit, mispredict, timeout
    txn(32'h40, 32'h0, 1, 32'h0, 0, 1'b0, 1'b0);
    txn(32'h40, 32'h0, 2, 32'h0, 0, 1'b0, 1'b0);
    txn(32'h40, 32'h5, 3, 32'h5, 0, 1'b0, 1'b0);
    check_idle("after_commit");
    txn(32'h40, 32'h5, 2, 32'h7, 3, 1'b0, 1'b0);
    check_idle("after_recover");
    txn(32'h40, 32'h9, 0, 32'h9, 0, 1'b0, 1'b0);
    txn(32'h40, 32'h9, 4, 32'h9, 0, 1'b0, 1'b0);
    txn(32'h40, 32'h9, TO + 5, 32'h9, 2, 1'b1, 1'b0);
    txn(32'h40, 32'h1, 0, 32'h1, 0, 1'b1, 1'b0);

    // Spurious recovery_done and dc_valid while idle
    bus.recovery_done = 1'b1;
    bus.dc_valid = 1'b1;
    @(negedge clk);
    bus.recovery_done = 1'b0;
    bus.dc_valid = 1'b0;
    idle_cycles(2, 1'b0, 1'b0);
    check_idle("spurious_idle");

    // Randomized traffic on a few aliased table entries
    for (int n = 0; n < 40; n++) begin
      pc = $urandom;
      pc[IW+1:2] = IW'($urandom_range(0, 3));
      pred = 32'($urandom_range(0, 3));
      data = ($urandom_range(0, 9) < 7) ? pred : (pred ^ 32'h1);
      txn(pc, pred,
          ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 4) : $urandom_range(0, 5),
          data, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end
    check_idle("after_random");

    // Reset while in RECOVER clears table: next load trains
    txn(32'h84, 32'h3, 1, 32'h3, 0, 1'b0, 1'b0);
    txn(32'h84, 32'h3, 1, 32'h3, 0, 1'b0, 1'b0);
    txn(32'h84, 32'h3, 1, 32'h4, 2, 1'b0, 1'b1);
    txn(32'h84, 32'h3, 1, 32'h3, 0, 1'b0, 1'b0);
    check_idle("post_reset");

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
